// File: rtl/exp6_unidade_controle_if.sv
// Control/status bundle between the game control unit (master) and the datapath (slave).
interface exp6_unidade_controle_if;
  logic       iniciar;
  logic       jogada_feita;
  logic       chavesIgualMemoria;
  logic       enderecoIgualSequencia;
  logic       fimL;
  logic       fimTMR;
  logic       timeout;

  logic       zeraE;
  logic       zeraL;
  logic       zeraR;
  logic       zeraM;
  logic       zeraTMR;
  logic       contaE;
  logic       contaL;
  logic       contaTMR;
  logic       registraR;
  logic       registraM;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       db_timeout;
  logic [4:0] db_estado;

  modport master (
    input  iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualSequencia,
           fimL, fimTMR, timeout,
    output zeraE, zeraL, zeraR, zeraM, zeraTMR, contaE, contaL, contaTMR,
           registraR, registraM, pronto, ganhou, perdeu, db_timeout, db_estado
  );

  modport slave (
    output iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualSequencia,
           fimL, fimTMR, timeout,
    input  zeraE, zeraL, zeraR, zeraM, zeraTMR, contaE, contaL, contaTMR,
           registraR, registraM, pronto, ganhou, perdeu, db_timeout, db_estado
  );
endinterface

// File: rtl/exp6_unidade_controle.sv
// Moore control unit for the memory-sequence game: show L+1 words, collect L+1 moves, grow L.
// Optional macro EXP6_TIMEOUT_EN enables the player inactivity timeout (state fim_timeout).
//
// state                  | meaning
// 00 inicial             | idle, waits for iniciar
// 01 preparacao          | clear address, sequence, move register, display, timer
// 02 carrega             | load memory word into display, clear timer
// 03 mostra              | display word until timer terminal
// 04 apaga               | blank display, clear timer
// 05 verifica_mostra     | last word of this round shown?
// 06 incrementa_mostra   | next display address
// 07 fim_mostra          | rewind address for player input
// 08 espera_jogada       | wait for a move (or timeout)
// 09 registra            | latch the move
// 0A comparacao          | verdict on the latched move
// 0B proxima_jogada      | next move address
// 0C ultima_sequencia    | was this the final round?
// 0D proxima_sequencia   | grow sequence, rewind address
// 0E acertou             | game won
// 0F errou               | game lost by wrong move
// 10 fim_timeout         | game lost by inactivity
module exp6_unidade_controle (
  input  logic                     clock,
  input  logic                     reset,
  exp6_unidade_controle_if.master  ctrl
);

  typedef enum logic [4:0] {
    INICIAL           = 5'h00,
    PREPARACAO        = 5'h01,
    CARREGA           = 5'h02,
    MOSTRA            = 5'h03,
    APAGA             = 5'h04,
    VERIFICA_MOSTRA   = 5'h05,
    INCREMENTA_MOSTRA = 5'h06,
    FIM_MOSTRA        = 5'h07,
    ESPERA_JOGADA     = 5'h08,
    REGISTRA          = 5'h09,
    COMPARACAO        = 5'h0A,
    PROXIMA_JOGADA    = 5'h0B,
    ULTIMA_SEQUENCIA  = 5'h0C,
    PROXIMA_SEQUENCIA = 5'h0D,
    ACERTOU           = 5'h0E,
    ERROU             = 5'h0F,
    FIM_TIMEOUT       = 5'h10
  } state_t;

  // Plain vector register so the unused codes 11h-1Fh are representable and decode safely.
  logic [4:0] state_q;
  logic [4:0] state_d;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = INICIAL;
    case (state_q)
      INICIAL:           state_d = ctrl.iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:        state_d = CARREGA;
      CARREGA:           state_d = MOSTRA;
      MOSTRA:            state_d = ctrl.fimTMR ? APAGA : MOSTRA;
      APAGA:             state_d = VERIFICA_MOSTRA;
      VERIFICA_MOSTRA:   state_d = ctrl.enderecoIgualSequencia ? FIM_MOSTRA : INCREMENTA_MOSTRA;
      INCREMENTA_MOSTRA: state_d = CARREGA;
      FIM_MOSTRA:        state_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A move landing in the same cycle as the timeout still counts.
        if (ctrl.jogada_feita) state_d = REGISTRA;
`ifdef EXP6_TIMEOUT_EN
        else if (ctrl.timeout) state_d = FIM_TIMEOUT;
`endif
        else state_d = ESPERA_JOGADA;
      end
      REGISTRA:          state_d = COMPARACAO;
      COMPARACAO: begin
        if (!ctrl.chavesIgualMemoria)          state_d = ERROU;
        else if (ctrl.enderecoIgualSequencia)  state_d = ULTIMA_SEQUENCIA;
        else                                   state_d = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA:    state_d = ESPERA_JOGADA;
      ULTIMA_SEQUENCIA:  state_d = ctrl.fimL ? ACERTOU : PROXIMA_SEQUENCIA;
      PROXIMA_SEQUENCIA: state_d = CARREGA;
      ACERTOU:           state_d = ctrl.iniciar ? PREPARACAO : ACERTOU;
      ERROU:             state_d = ctrl.iniciar ? PREPARACAO : ERROU;
`ifdef EXP6_TIMEOUT_EN
      FIM_TIMEOUT:       state_d = ctrl.iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
      default:           state_d = INICIAL;
    endcase
  end

  always_comb begin
    ctrl.zeraE      = 1'b0;
    ctrl.zeraL      = 1'b0;
    ctrl.zeraR      = 1'b0;
    ctrl.zeraM      = 1'b0;
    ctrl.zeraTMR    = 1'b0;
    ctrl.contaE     = 1'b0;
    ctrl.contaL     = 1'b0;
    ctrl.contaTMR   = 1'b0;
    ctrl.registraR  = 1'b0;
    ctrl.registraM  = 1'b0;
    ctrl.pronto     = 1'b0;
    ctrl.ganhou     = 1'b0;
    ctrl.perdeu     = 1'b0;
    ctrl.db_timeout = 1'b0;
    case (state_q)
      PREPARACAO: begin
        ctrl.zeraE   = 1'b1;
        ctrl.zeraL   = 1'b1;
        ctrl.zeraR   = 1'b1;
        ctrl.zeraM   = 1'b1;
        ctrl.zeraTMR = 1'b1;
      end
      CARREGA: begin
        ctrl.registraM = 1'b1;
        ctrl.zeraTMR   = 1'b1;
      end
      MOSTRA:            ctrl.contaTMR = 1'b1;
      APAGA: begin
        ctrl.zeraM   = 1'b1;
        ctrl.zeraTMR = 1'b1;
      end
      INCREMENTA_MOSTRA: ctrl.contaE = 1'b1;
      FIM_MOSTRA: begin
        ctrl.zeraE = 1'b1;
        ctrl.zeraR = 1'b1;
      end
      REGISTRA:          ctrl.registraR = 1'b1;
      PROXIMA_JOGADA:    ctrl.contaE = 1'b1;
      PROXIMA_SEQUENCIA: begin
        ctrl.contaL = 1'b1;
        ctrl.zeraE  = 1'b1;
        ctrl.zeraR  = 1'b1;
      end
      ACERTOU: begin
        ctrl.pronto = 1'b1;
        ctrl.ganhou = 1'b1;
      end
      ERROU: begin
        ctrl.pronto = 1'b1;
        ctrl.perdeu = 1'b1;
      end
`ifdef EXP6_TIMEOUT_EN
      FIM_TIMEOUT: begin
        ctrl.pronto     = 1'b1;
        ctrl.perdeu     = 1'b1;
        ctrl.db_timeout = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign ctrl.db_estado = state_q;

endmodule
